// File: rtl/data_mux_sched_if.sv
// Scheduler-to-mux control bundle: the select/link-reset outputs and the monitored
// output handshake of the data mux.
interface data_mux_sched_if #(
    parameter int SEL_WIDTH = 4
);
    logic [SEL_WIDTH-1:0] output_select;
    logic                 fc_linkReset;
    logic                 tvalid_out;
    logic                 tready_out;

    modport master (
        output output_select,
        output fc_linkReset,
        input  tvalid_out,
        input  tready_out
    );

    modport slave (
        input  output_select,
        input  fc_linkReset,
        output tvalid_out,
        output tready_out
    );
endinterface

// File: rtl/data_mux_sched.sv
// Round-robin dwell scheduler for the data mux: select next enabled input, pulse a
// link reset, wait out the idle burst, then hold for a programmed number of beats.
module data_mux_sched #(
    parameter int N_INPUTS    = 16,
    parameter int SEL_WIDTH   = 4,
    parameter int DWELL_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [N_INPUTS-1:0]    channel_mask,
    input  logic [DWELL_WIDTH-1:0] dwell_words,
    input  logic [15:0]            n_idle_words,
    input  logic                   switch_on_orbit,
    input  logic                   fc_orbitSync,
    data_mux_sched_if.master       mux,
    output logic                   busy,
    output logic [15:0]            switch_count
);

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_WAIT_ORBIT = 3'd1;
    localparam logic [2:0] ST_LINKRST    = 3'd2;
    localparam logic [2:0] ST_SETTLE     = 3'd3;
    localparam logic [2:0] ST_SEND       = 3'd4;

    localparam logic [SEL_WIDTH-1:0] LAST_SEL_INIT = SEL_WIDTH'(N_INPUTS - 1);
    localparam logic [SEL_WIDTH:0]   N_WIDE        = (SEL_WIDTH + 1)'(N_INPUTS);

    logic [2:0]             state_reg,      state_next;
    logic [SEL_WIDTH-1:0]   sel_reg,        sel_next;
    logic [SEL_WIDTH-1:0]   last_sel_reg,   last_sel_next;
    logic                   link_rst_reg,   link_rst_next;
    logic [DWELL_WIDTH-1:0] idle_cnt_reg,   idle_cnt_next;
    logic [DWELL_WIDTH-1:0] dwell_cnt_reg,  dwell_cnt_next;
    logic [15:0]            switch_cnt_reg, switch_cnt_next;

    logic                   mask_any;
    logic                   beat;
    logic                   idle_tick;
    logic [DWELL_WIDTH-1:0] dwell_load;
    logic [SEL_WIDTH-1:0]   next_sel;

    // Candidate k is the input k+1 positions after the last selection, wrapped.
    logic [SEL_WIDTH:0]     cand_sum [N_INPUTS];
    logic [SEL_WIDTH-1:0]   cand_idx [N_INPUTS];
    logic [N_INPUTS-1:0]    rot_mask;

    generate
        for (genvar gi = 0; gi < N_INPUTS; gi++) begin : g_cand
            assign cand_sum[gi] = {1'b0, last_sel_reg} + (SEL_WIDTH + 1)'(gi + 1);
            assign cand_idx[gi] = (cand_sum[gi] >= N_WIDE) ? SEL_WIDTH'(cand_sum[gi] - N_WIDE)
                                                           : SEL_WIDTH'(cand_sum[gi]);
            assign rot_mask[gi] = channel_mask[cand_idx[gi]];
        end
    endgenerate

    always_comb begin
        next_sel = last_sel_reg;
        for (int k = N_INPUTS - 1; k >= 0; k--) begin
            if (rot_mask[k]) begin
                next_sel = cand_idx[k];
            end
        end
    end

    assign mask_any   = |channel_mask;
    assign beat       = mux.tvalid_out && mux.tready_out;
    assign idle_tick  = mux.tready_out;
    assign dwell_load = (dwell_words == '0) ? DWELL_WIDTH'(1) : dwell_words;

    always_comb begin
        state_next      = state_reg;
        sel_next        = sel_reg;
        last_sel_next   = last_sel_reg;
        link_rst_next   = 1'b0;
        idle_cnt_next   = idle_cnt_reg;
        dwell_cnt_next  = dwell_cnt_reg;
        switch_cnt_next = switch_cnt_reg;

        case (state_reg)
            ST_IDLE: begin
                if (enable && mask_any) begin
                    state_next = switch_on_orbit ? ST_WAIT_ORBIT : ST_LINKRST;
                end
            end

            ST_WAIT_ORBIT: begin
                if (!enable || !mask_any) begin
                    state_next = ST_IDLE;
                end else if (fc_orbitSync) begin
                    state_next = ST_LINKRST;
                end
            end

            ST_LINKRST: begin
                if (!mask_any) begin
                    state_next = ST_IDLE;
                end else begin
                    link_rst_next  = 1'b1;
                    sel_next       = next_sel;
                    last_sel_next  = next_sel;
                    idle_cnt_next  = DWELL_WIDTH'(n_idle_words);
                    dwell_cnt_next = dwell_load;
                    state_next     = (n_idle_words == 16'd0) ? ST_SEND : ST_SETTLE;
                end
            end

            ST_SETTLE: begin
                // The mux starts its own idle countdown only after it has seen the pulse,
                // so the cycle in which the pulse is on the port is not counted.
                if (!link_rst_reg && idle_tick) begin
                    idle_cnt_next = idle_cnt_reg - DWELL_WIDTH'(1);
                    if (idle_cnt_reg == DWELL_WIDTH'(1)) begin
                        dwell_cnt_next = dwell_load;
                        state_next     = ST_SEND;
                    end
                end
            end

            ST_SEND: begin
                if (beat) begin
                    dwell_cnt_next = dwell_cnt_reg - DWELL_WIDTH'(1);
                    if (dwell_cnt_reg == DWELL_WIDTH'(1)) begin
                        switch_cnt_next = switch_cnt_reg + 16'd1;
                        if (!enable || !mask_any) begin
                            state_next = ST_IDLE;
                        end else begin
                            state_next = switch_on_orbit ? ST_WAIT_ORBIT : ST_LINKRST;
                        end
                    end
                end
            end

            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            sel_reg        <= '0;
            last_sel_reg   <= LAST_SEL_INIT;
            link_rst_reg   <= 1'b0;
            idle_cnt_reg   <= '0;
            dwell_cnt_reg  <= '0;
            switch_cnt_reg <= '0;
        end else begin
            state_reg      <= state_next;
            sel_reg        <= sel_next;
            last_sel_reg   <= last_sel_next;
            link_rst_reg   <= link_rst_next;
            idle_cnt_reg   <= idle_cnt_next;
            dwell_cnt_reg  <= dwell_cnt_next;
            switch_cnt_reg <= switch_cnt_next;
        end
    end

    assign mux.output_select = sel_reg;
    assign mux.fc_linkReset  = link_rst_reg;
    assign busy              = (state_reg != ST_IDLE);
    assign switch_count      = switch_cnt_reg;

endmodule

// File: tb/tb_data_mux_sched.sv
// Directed bench for data_mux_sched: rotation, orbit-gated switching, handshake-gated
// counting, boundary values, enable/mask withdrawal and mid-run reset.
module tb_data_mux_sched;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [15:0] channel_mask;
    logic [15:0] dwell_words;
    logic [15:0] n_idle_words;
    logic        switch_on_orbit;
    logic        fc_orbitSync;
    logic        busy;
    logic [15:0] switch_count;

    int total = 0;
    int bad   = 0;
    bit toggle_rdy = 0;
    int n;
    bit pulsed;

    data_mux_sched_if #(.SEL_WIDTH(4)) bus ();

    data_mux_sched #(
        .N_INPUTS   (16),
        .SEL_WIDTH  (4),
        .DWELL_WIDTH(16)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .channel_mask   (channel_mask),
        .dwell_words    (dwell_words),
        .n_idle_words   (n_idle_words),
        .switch_on_orbit(switch_on_orbit),
        .fc_orbitSync   (fc_orbitSync),
        .mux            (bus),
        .busy           (busy),
        .switch_count   (switch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        if (toggle_rdy) bus.tready_out = ~bus.tready_out;
    endtask

    task automatic wait_pulse(input string tag, output int cycles);
        cycles = 0;
        do begin
            step();
            cycles++;
        end while (bus.fc_linkReset !== 1'b1 && cycles < 60);
        chk({tag, "_pulse_seen"}, 32'(bus.fc_linkReset), 32'd1);
    endtask

    task automatic wait_idle(input string tag, output int cycles, output bit saw_pulse);
        cycles    = 0;
        saw_pulse = 0;
        do begin
            step();
            cycles++;
            if (bus.fc_linkReset === 1'b1) saw_pulse = 1;
        end while (busy !== 1'b0 && cycles < 60);
        chk({tag, "_idle_reached"}, 32'(busy), 32'd0);
    endtask

    task automatic quiet(input int cycles, output bit saw_pulse);
        saw_pulse = 0;
        for (int i = 0; i < cycles; i++) begin
            step();
            if (bus.fc_linkReset === 1'b1) saw_pulse = 1;
        end
    endtask

    initial begin
        reset           = 1'b1;
        enable          = 1'b0;
        channel_mask    = 16'h0000;
        dwell_words     = 16'd0;
        n_idle_words    = 16'd0;
        switch_on_orbit = 1'b0;
        fc_orbitSync    = 1'b0;
        bus.tvalid_out  = 1'b0;
        bus.tready_out  = 1'b0;
        step();
        step();
        chk("rst_sel",  32'(bus.output_select), 32'd0);
        chk("rst_lrst", 32'(bus.fc_linkReset),  32'd0);
        chk("rst_busy", 32'(busy),              32'd0);
        chk("rst_swc",  32'(switch_count),      32'd0);
        reset = 1'b0;
        step();
        chk("idle_busy", 32'(busy), 32'd0);
        $display("txn reset: outputs at reset values");

        // Rotation over inputs 0 and 2: pulse, 2 idle ticks, 3 beats, next pulse 7 cycles on.
        channel_mask   = 16'h0005;
        dwell_words    = 16'd3;
        n_idle_words   = 16'd2;
        bus.tvalid_out = 1'b1;
        bus.tready_out = 1'b1;
        enable         = 1'b1;
        wait_pulse("rr0", n);
        chk("rr0_latency", 32'(n), 32'd2);
        chk("rr0_sel", 32'(bus.output_select), 32'd0);
        chk("rr0_swc", 32'(switch_count), 32'd0);
        $display("txn rr pulse 0: sel=%0d after %0d cycles", bus.output_select, n);
        for (int k = 1; k <= 3; k++) begin
            wait_pulse("rr", n);
            chk("rr_gap", 32'(n), 32'd7);
            chk("rr_sel", 32'(bus.output_select), (k % 2 == 1) ? 32'd2 : 32'd0);
            chk("rr_swc", 32'(switch_count), 32'(k));
            $display("txn rr pulse %0d: sel=%0d gap=%0d swc=%0d", k, bus.output_select, n, switch_count);
        end
        enable = 1'b0;
        wait_idle("rr_stop", n, pulsed);
        chk("rr_stop_cycles", 32'(n), 32'd6);
        chk("rr_stop_nopulse", 32'(pulsed), 32'd0);
        chk("rr_stop_swc", 32'(switch_count), 32'd4);
        quiet(10, pulsed);
        chk("rr_quiet", 32'(pulsed), 32'd0);
        $display("txn rr stop: idle after %0d cycles swc=%0d", n, switch_count);

        // Enable dropped mid-dwell with idle=0: dwell of 4 still completes.
        dwell_words  = 16'd4;
        n_idle_words = 16'd0;
        enable       = 1'b1;
        wait_pulse("dis", n);
        chk("dis_latency", 32'(n), 32'd2);
        chk("dis_sel", 32'(bus.output_select), 32'd0);
        step();
        enable = 1'b0;
        wait_idle("dis", n, pulsed);
        chk("dis_cycles", 32'(n), 32'd3);
        chk("dis_nopulse", 32'(pulsed), 32'd0);
        chk("dis_swc", 32'(switch_count), 32'd5);
        $display("txn enable drop in SEND: idle after %0d cycles swc=%0d", n, switch_count);

        // tready toggling: 2 idle ticks take 4 cycles, a dwell of 4 takes 8.
        dwell_words    = 16'd4;
        n_idle_words   = 16'd2;
        bus.tready_out = 1'b1;
        toggle_rdy     = 1'b1;
        enable         = 1'b1;
        wait_pulse("tog", n);
        chk("tog_sel", 32'(bus.output_select), 32'd2);
        enable = 1'b0;
        wait_idle("tog", n, pulsed);
        chk("tog_cycles", 32'(n), 32'd13);
        chk("tog_swc", 32'(switch_count), 32'd6);
        toggle_rdy     = 1'b0;
        bus.tready_out = 1'b1;
        $display("txn tready toggle: pulse to idle %0d cycles swc=%0d", n, switch_count);

        // dwell=0 acts as 1, and beats need tvalid as well as tready.
        dwell_words    = 16'd0;
        n_idle_words   = 16'd0;
        bus.tvalid_out = 1'b0;
        enable         = 1'b1;
        wait_pulse("vld", n);
        chk("vld_sel", 32'(bus.output_select), 32'd0);
        enable = 1'b0;
        quiet(5, pulsed);
        chk("vld_hold_busy", 32'(busy), 32'd1);
        bus.tvalid_out = 1'b1;
        step();
        chk("vld_done_busy", 32'(busy), 32'd0);
        chk("vld_swc", 32'(switch_count), 32'd7);
        $display("txn tvalid gating, dwell=0: swc=%0d", switch_count);

        // Single enabled input 15 reselects itself; idle=0 gives a 2-cycle period.
        channel_mask = 16'h8000;
        dwell_words  = 16'd1;
        enable       = 1'b1;
        wait_pulse("one0", n);
        chk("one0_sel", 32'(bus.output_select), 32'd15);
        wait_pulse("one1", n);
        chk("one1_gap", 32'(n), 32'd2);
        chk("one1_sel", 32'(bus.output_select), 32'd15);
        enable = 1'b0;
        step();
        chk("one_busy", 32'(busy), 32'd0);
        chk("one_swc", 32'(switch_count), 32'd9);
        $display("txn single input: sel=%0d swc=%0d", bus.output_select, switch_count);

        // Orbit-gated switching: LINKRST follows the sync cycle, pulse is on the port next.
        channel_mask    = 16'h0005;
        dwell_words     = 16'd1;
        n_idle_words    = 16'd1;
        switch_on_orbit = 1'b1;
        enable          = 1'b1;
        step();
        chk("orb_wait_busy", 32'(busy), 32'd1);
        quiet(6, pulsed);
        chk("orb_nosync0", 32'(pulsed), 32'd0);
        fc_orbitSync = 1'b1;
        step();
        fc_orbitSync = 1'b0;
        chk("orb0_early", 32'(bus.fc_linkReset), 32'd0);
        step();
        chk("orb0_pulse", 32'(bus.fc_linkReset), 32'd1);
        chk("orb0_sel", 32'(bus.output_select), 32'd0);
        $display("txn orbit switch 0: sel=%0d", bus.output_select);
        quiet(9, pulsed);
        chk("orb_nosync1", 32'(pulsed), 32'd0);
        fc_orbitSync = 1'b1;
        step();
        fc_orbitSync = 1'b0;
        step();
        chk("orb1_pulse", 32'(bus.fc_linkReset), 32'd1);
        chk("orb1_sel", 32'(bus.output_select), 32'd2);
        chk("orb1_swc", 32'(switch_count), 32'd10);
        $display("txn orbit switch 1: sel=%0d swc=%0d", bus.output_select, switch_count);
        step();
        step();
        step();
        chk("orb_wait2_busy", 32'(busy), 32'd1);
        channel_mask = 16'h0000;
        step();
        chk("orb_mask0_busy", 32'(busy), 32'd0);
        chk("orb_mask0_lrst", 32'(bus.fc_linkReset), 32'd0);
        chk("orb_mask0_swc", 32'(switch_count), 32'd11);
        $display("txn mask cleared in WAIT_ORBIT: busy=%0d", busy);

        // Reset while settling, then restart from input search origin.
        switch_on_orbit = 1'b0;
        channel_mask    = 16'h0004;
        dwell_words     = 16'd2;
        n_idle_words    = 16'd3;
        enable          = 1'b1;
        wait_pulse("pre", n);
        chk("pre_sel", 32'(bus.output_select), 32'd2);
        step();
        reset = 1'b1;
        step();
        chk("mrst_sel",  32'(bus.output_select), 32'd0);
        chk("mrst_lrst", 32'(bus.fc_linkReset),  32'd0);
        chk("mrst_busy", 32'(busy),              32'd0);
        chk("mrst_swc",  32'(switch_count),      32'd0);
        channel_mask = 16'h0002;
        reset        = 1'b0;
        wait_pulse("post", n);
        chk("post_latency", 32'(n), 32'd2);
        chk("post_sel", 32'(bus.output_select), 32'd1);
        $display("txn reset in SETTLE: restart sel=%0d", bus.output_select);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
